seq_entry_tracker: RTL and testbench

- Per-player front end of the timed two-player sequence-matching game; one instance per player.
- Captures the 4-symbol target sequence when a round starts and checks the player's key presses against it in order.
- Drives a 4-bit progress vector that feeds the winner-checking stage downstream; the value 4'b1111 means "sequence complete".
- Enforces a per-symbol time limit; on timeout the player is locked out for the round.

---
 rtl/seq_entry_tracker.sv | 142 ++++++++++++++
 tb/tb_seq_entry_tracker.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_entry_tracker.sv
// Per-player sequence-entry front end: captures a 4-symbol target on the round start,
// matches key presses in order, and flags completion or a per-symbol timeout.
module seq_entry_tracker #(
   parameter int unsigned TIMEOUT_CYCLES = 50000000,
   parameter int unsigned TMR_W          = 26
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       Start,
   input  logic [7:0] Seq,
   input  logic [1:0] Key,
   input  logic       KeyValid,
   output logic [3:0] Prog,
   output logic       Done,
   output logic       Timeout
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      DONE = 2'd2,
      FAIL = 2'd3
   } state_t;

   localparam logic [TMR_W-1:0] RELOAD = TMR_W'(TIMEOUT_CYCLES - 1);

   state_t           state_q, state_n;
   logic [3:0]       prog_q, prog_n;
   logic             done_q, done_n;
   logic             timeout_q, timeout_n;
   logic [1:0]       idx_q, idx_n;
   logic [TMR_W-1:0] timer_q, timer_n;
   logic [7:0]       seq_q, seq_n;
   logic             start_q;

   logic             start_rise;
   logic [1:0]       expected_sym;

   assign start_rise   = Start && !start_q;
   assign expected_sym = seq_q[{idx_q, 1'b0} +: 2];

   // NOTE: registers use non-blocking assignments only, so every flop samples the
   // pre-edge value of the others regardless of process ordering.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q   <= IDLE;
         prog_q    <= '0;
         done_q    <= 1'b0;
         timeout_q <= 1'b0;
         idx_q     <= '0;
         timer_q   <= '0;
         seq_q     <= '0;
         start_q   <= 1'b0;
      end else begin
         state_q   <= state_n;
         prog_q    <= prog_n;
         done_q    <= done_n;
         timeout_q <= timeout_n;
         idx_q     <= idx_n;
         timer_q   <= timer_n;
         seq_q     <= seq_n;
         start_q   <= Start;
      end
   end

   // NOTE: every signal driven here gets a hold/default value first, so no path
   // through the case leaves one unassigned and no latch is inferred.
   always_comb begin
      state_n = state_q;
      prog_n  = prog_q;
      idx_n   = idx_q;
      timer_n = timer_q;
      seq_n   = seq_q;

      case (state_q)
         IDLE: begin
            prog_n = '0;
            if (start_rise) begin
               seq_n   = Seq;
               idx_n   = '0;
               timer_n = RELOAD;
               state_n = PLAY;
            end
         end

         // Abort beats key, key beats expiry: a press landing on timer == 0 still counts.
         PLAY: begin
            if (!Start) begin
               state_n = IDLE;
               prog_n  = '0;
            end else if (KeyValid) begin
               if (Key == expected_sym) begin
                  prog_n[idx_q] = 1'b1;
                  if (idx_q == 2'd3) begin
                     state_n = DONE;
                  end else begin
                     idx_n   = idx_q + 2'd1;
                     timer_n = RELOAD;
                  end
               end else begin
                  prog_n  = '0;
                  idx_n   = '0;
                  timer_n = RELOAD;
               end
            end else if (timer_q == '0) begin
               state_n = FAIL;
               prog_n  = '0;
            end else begin
               timer_n = timer_q - 1'b1;
            end
         end

         DONE: begin
            prog_n = 4'b1111;
            if (!Start) begin
               state_n = IDLE;
               prog_n  = '0;
            end
         end

         FAIL: begin
            prog_n = '0;
            if (!Start) state_n = IDLE;
         end

         default: begin
            state_n = IDLE;
            prog_n  = '0;
            idx_n   = '0;
            timer_n = '0;
         end
      endcase

      done_n    = (state_n == DONE);
      timeout_n = (state_n == FAIL);
   end

   assign Prog    = prog_q;
   assign Done    = done_q;
   assign Timeout = timeout_q;

endmodule

// File: tb/tb_seq_entry_tracker.sv
// Self-checking bench for seq_entry_tracker: directed scenarios followed by random
// rounds, all compared every cycle against a round-level reference model.
module tb_seq_entry_tracker;

   localparam int T = 8;

   logic       Clk = 1'b0;
   logic       Rst;
   logic       Start;
   logic [7:0] Seq;
   logic [1:0] Key;
   logic       KeyValid;
   logic [3:0] Prog;
   logic       Done;
   logic       Timeout;

   int checks = 0;
   int errors = 0;

   // Reference model: a round is "active" once armed; it is won, lost, or still being
   // played at position m_pos with m_elapsed idle cycles since the last reload.
   bit         m_active, m_won, m_lost, m_start_prev;
   int         m_pos, m_elapsed;
   logic [1:0] m_target [4];

   always #5 Clk = ~Clk;

   seq_entry_tracker #(.TIMEOUT_CYCLES(T), .TMR_W(4)) dut (
      .Clk     (Clk),
      .Rst     (Rst),
      .Start   (Start),
      .Seq     (Seq),
      .Key     (Key),
      .KeyValid(KeyValid),
      .Prog    (Prog),
      .Done    (Done),
      .Timeout (Timeout)
   );

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_won = 0; m_lost = 0; m_start_prev = 0;
      m_pos = 0; m_elapsed = 0;
      for (int i = 0; i < 4; i++) m_target[i] = 2'd0;
   endtask

   task automatic model_step();
      if (!m_active) begin
         if (Start && !m_start_prev) begin
            for (int i = 0; i < 4; i++) m_target[i] = Seq[2*i +: 2];
            m_active = 1; m_won = 0; m_lost = 0; m_pos = 0; m_elapsed = 0;
         end
      end else if (m_won || m_lost) begin
         if (!Start) begin
            m_active = 0; m_won = 0; m_lost = 0; m_pos = 0;
         end
      end else if (!Start) begin
         m_active = 0; m_pos = 0;
      end else if (KeyValid) begin
         m_elapsed = 0;
         if (Key == m_target[m_pos]) begin
            m_pos++;
            if (m_pos == 4) m_won = 1;
         end else begin
            m_pos = 0;
         end
      end else if (m_elapsed == T - 1) begin
         m_lost = 1; m_pos = 0;
      end else begin
         m_elapsed++;
      end
      m_start_prev = Start;
   endtask

   task automatic check_outputs(input string tag);
      logic [3:0] exp_prog;
      if (m_won)                    exp_prog = 4'b1111;
      else if (m_active && !m_lost) exp_prog = 4'((1 << m_pos) - 1);
      else                          exp_prog = 4'b0000;
      check({tag, ".prog"}, Prog, exp_prog);
      check({tag, ".done"}, {3'b0, Done}, {3'b0, m_won});
      check({tag, ".timeout"}, {3'b0, Timeout}, {3'b0, m_lost});
   endtask

   task automatic cycle(input string tag = "cyc");
      @(posedge Clk);
      model_step();
      @(negedge Clk);
      check_outputs(tag);
   endtask

   task automatic idle(input int n);
      repeat (n) cycle("idle");
   endtask

   task automatic press(input logic [1:0] k);
      Key = k;
      KeyValid = 1'b1;
      cycle("key");
      KeyValid = 1'b0;
   endtask

   initial begin
      Rst = 1'b0; Start = 1'b0; Seq = 8'h00; Key = 2'd0; KeyValid = 1'b0;
      model_reset();
      #1;
      check_outputs("reset");
      repeat (2) @(negedge Clk);
      Rst = 1'b1;
      idle(2);

      // In-order entry of the target sequence
      Seq = 8'b11_10_01_00;
      Start = 1'b1;
      cycle("arm");
      for (int k = 0; k < 4; k++) begin
         press(2'(k));
         idle(1);
      end
      check("seq_done", {3'b0, Done}, 4'b0001);
      Start = 1'b0;
      idle(2);

      // Wrong key restarts from symbol0, then a full correct entry
      Start = 1'b1;
      cycle("arm");
      press(2'd0); idle(1);
      press(2'd1); idle(1);
      press(2'd3);
      check("wrong_key_prog", Prog, 4'b0000);
      idle(1);
      for (int k = 0; k < 4; k++) begin
         press(2'(k));
         idle(1);
      end
      check("retry_prog", Prog, 4'b1111);
      Start = 1'b0;
      idle(2);

      // No key at all: timeout on the T-th clock after arming
      Start = 1'b1;
      cycle("arm");
      idle(T - 1);
      check("pre_timeout", {3'b0, Timeout}, 4'b0000);
      idle(1);
      check("timeout", {3'b0, Timeout}, 4'b0001);
      press(2'd0);
      press(2'd1);
      check("fail_locked", Prog, 4'b0000);
      Start = 1'b0;
      cycle("drop");
      check("timeout_clear", {3'b0, Timeout}, 4'b0000);

      // Key arriving exactly when the timer reads zero is accepted
      Start = 1'b1;
      cycle("arm");
      idle(T - 1);
      press(2'd0);
      check("tie_prog", Prog, 4'b0001);
      check("tie_timeout", {3'b0, Timeout}, 4'b0000);
      idle(T - 1);
      press(2'd1);
      check("tie2_prog", Prog, 4'b0011);

      // Abort mid-round, then a new round captures the new target
      Start = 1'b0;
      cycle("abort");
      check("abort_prog", Prog, 4'b0000);
      Seq = 8'b00_01_10_11;
      Start = 1'b1;
      cycle("arm");
      press(2'd3);
      check("new_seq_prog", Prog, 4'b0001);
      press(2'd2); press(2'd1); press(2'd0);
      idle(3);
      check("done_hold", {3'b0, Done}, 4'b0001);

      // Asynchronous reset between edges while in DONE, Start held high at release
      #2;
      Rst = 1'b0;
      #1;
      model_reset();
      check("async_prog", Prog, 4'b0000);
      check("async_done", {3'b0, Done}, 4'b0000);
      check("async_timeout", {3'b0, Timeout}, 4'b0000);
      @(negedge Clk);
      Rst = 1'b1;
      cycle("rearm");
      press(2'd3);
      check("post_reset_prog", Prog, 4'b0001);
      Start = 1'b0;
      idle(2);

      // Random rounds: random targets, gaps, mostly-correct keys, occasional aborts
      for (int r = 0; r < 30; r++) begin
         Seq = 8'($urandom);
         Start = 1'b1;
         cycle("rnd_arm");
         for (int s = 0; s < 12; s++) begin
            logic [1:0] k;
            idle($urandom_range(0, T + 1));
            if (m_active && !m_won && !m_lost && m_pos < 4 && $urandom_range(0, 9) < 7)
               k = m_target[m_pos];
            else
               k = 2'($urandom);
            press(k);
            if ($urandom_range(0, 19) == 0) begin
               Start = 1'b0;
               cycle("rnd_drop");
               Start = 1'b1;
            end
         end
         Start = 1'b0;
         cycle("rnd_end");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
